// File: rtl/ntt_array_sequencer_pkg.sv
// Shared constants and state encoding for the 16-PE NTT array sequencer.
// The array itself works modulo NTT_Q with primitive 16th root NTT_ROOT.
package ntt_pkg;

  localparam int NTT_N    = 16;
  localparam int NTT_Q    = 7681;
  localparam int NTT_ROOT = 7098;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_STREAM = 3'd2;
  localparam logic [2:0] ST_DRAIN  = 3'd3;
  localparam logic [2:0] ST_OUTPUT = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    LOAD   = ST_LOAD,
    STREAM = ST_STREAM,
    DRAIN  = ST_DRAIN,
    OUTPUT = ST_OUTPUT
  } state_t;

endpackage

// File: rtl/ntt_array_sequencer_result_buffer.sv
// N x DW result register file: one synchronous write port, one combinational read port.
// Contents are data only and carry no reset.
module ntt_result_buffer
  import ntt_pkg::*;
#(
  parameter int N  = NTT_N,
  parameter int DW = 32,
  parameter int IW = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [IW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [IW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_q [N];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/ntt_array_sequencer.sv
// Sequencer for the linear NTT systolic array: loads coefficients into the PEs,
// streams output indices, captures the last PE's results and drains them to the host.
module ntt_array_sequencer
  import ntt_pkg::*;
#(
  parameter int N  = NTT_N,
  parameter int DW = 32,
  parameter int IW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [IW-1:0] out_index,
  output logic          arr_rst,
  output logic [DW-1:0] arr_en_index,
  output logic [DW-1:0] arr_val0,
  output logic [DW-1:0] arr_val1,
  output logic [DW-1:0] arr_lane0,
  output logic [DW-1:0] arr_lane1,
  input  logic [DW-1:0] arr_result
);

  // cnt spans 0..2N-1 across STREAM and DRAIN, so it needs one bit more than an index
  localparam int CW = IW + 1;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] rd_q, rd_d;
  logic          buf_we;
  logic [IW-1:0] buf_waddr;
  logic [DW-1:0] buf_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rd_d         = rd_q;
    busy         = (state_q != IDLE);
    done         = 1'b0;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    arr_rst      = rst;
    arr_en_index = '0;
    arr_val0     = '0;
    arr_val1     = '0;
    arr_lane0    = '0;
    arr_lane1    = '0;
    buf_we       = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end

      // Array held in reset so its twiddle table reloads while PEs take coefficients
      LOAD: begin
        arr_rst  = 1'b1;
        in_ready = 1'b1;
        arr_val0 = DW'(cnt_q);
        arr_val1 = in_data;
        if (in_valid) begin
          arr_en_index = DW'(cnt_q) + DW'(1);
          if (cnt_q == CW'(N - 1)) begin
            state_d = STREAM;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      STREAM: begin
        arr_lane0 = DW'(cnt_q);
        cnt_d     = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) state_d = DRAIN;
      end

      // Array latency is exactly N, so result n arrives while cnt = n + N
      DRAIN: begin
        buf_we = (cnt_q >= CW'(N));
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(2 * N - 1)) begin
          state_d = OUTPUT;
          cnt_d   = '0;
          rd_d    = '0;
        end
      end

      OUTPUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          rd_d = rd_q + IW'(1);
          if (rd_q == IW'(N - 1)) begin
            done    = 1'b1;
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // N is a power of two, so the low bits of cnt are cnt - N during capture
  assign buf_waddr = cnt_q[IW-1:0];

  ntt_result_buffer #(
    .N  (N),
    .DW (DW),
    .IW (IW)
  ) u_result_buffer (
    .clk   (clk),
    .we    (buf_we),
    .waddr (buf_waddr),
    .wdata (arr_result),
    .raddr (rd_q),
    .rdata (buf_rdata)
  );

  assign out_data  = buf_rdata;
  assign out_index = rd_q;

endmodule

// File: tb/tb_ntt_array_sequencer.sv
// Directed bench for ntt_array_sequencer with a behavioural model of the 16-PE array.
// The array model holds the coefficients the sequencer writes and answers lane0 indices N cycles later.
module tb_ntt_array_sequencer;

  localparam int N  = 16;
  localparam int DW = 32;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst, start, in_valid, out_ready;
  logic [DW-1:0] in_data, arr_result;
  logic          busy, done, in_ready, out_valid, arr_rst;
  logic [DW-1:0] out_data, arr_en_index, arr_val0, arr_val1, arr_lane0, arr_lane1;
  logic [IW-1:0] out_index;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ntt_array_sequencer #(.N(N), .DW(DW), .IW(IW)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_index(out_index),
    .arr_rst(arr_rst), .arr_en_index(arr_en_index), .arr_val0(arr_val0), .arr_val1(arr_val1),
    .arr_lane0(arr_lane0), .arr_lane1(arr_lane1), .arr_result(arr_result)
  );

  // X[n] = sum a_k * 7098^(nk mod 16) mod 7681
  function automatic logic [31:0] golden(input int n, input logic [31:0] a [16]);
    longint acc, w;
    acc = 0;
    for (int k = 0; k < 16; k++) begin
      w = 1;
      for (int e = 0; e < ((n * k) % 16); e++) w = (w * 7098) % 7681;
      acc = (acc + (longint'({32'b0, a[k]}) % 7681) * w) % 7681;
    end
    return acc[31:0];
  endfunction

  logic [31:0] coef  [16];
  logic [31:0] rpipe [16];

  always @(posedge clk) begin
    if (arr_en_index != 0 && arr_en_index <= 16) coef[arr_en_index[3:0] - 4'd1] <= arr_val1;
    rpipe[0] <= golden(int'(arr_lane0[3:0]), coef);
    for (int i = 15; i > 0; i--) rpipe[i] <= rpipe[i-1];
  end
  assign arr_result = rpipe[15];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_xform(input logic [31:0] a [16], input int bubble_every, input int stall_at,
                           input bit start_noise, output logic [31:0] res [16],
                           output logic [3:0] idx [16], output int n_done, output int obs_bad,
                           output bit tmo);
    int k, cyc, guard;
    logic [31:0] hd;
    logic [3:0]  hi;
    n_done = 0; obs_bad = 0; tmo = 0;
    for (int i = 0; i < 16; i++) begin res[i] = '0; idx[i] = '0; end
    start = 1; tick(); start = 0;
    k = 0; cyc = 0;
    while (k < N && cyc < 200) begin
      if (bubble_every > 0 && (cyc % bubble_every) == bubble_every - 1) begin
        in_valid = 0; in_data = 32'hDEAD_BEEF; #1;
        if (arr_en_index !== 0 || in_ready !== 1) obs_bad++;
      end else begin
        in_valid = 1; in_data = a[k]; start = start_noise && (k == 5); #1;
        if (in_ready !== 1 || arr_en_index !== k + 1 || arr_val0 !== k || arr_val1 !== a[k]) obs_bad++;
        k++;
      end
      tick(); start = 0; cyc++;
    end
    in_valid = 0; in_data = 0;
    if (k < N) tmo = 1;
    guard = 0;
    while (out_valid !== 1 && guard < 100) begin tick(); guard++; end
    if (guard >= 100) tmo = 1;
    out_ready = 1;
    for (int i = 0; i < N && !tmo; i++) begin
      if (i == stall_at) begin
        out_ready = 0; hd = out_data; hi = out_index;
        for (int s = 0; s < 5; s++) begin
          start = start_noise; #1;
          if (out_valid !== 1 || out_data !== hd || out_index !== hi || done !== 0) obs_bad++;
          tick(); start = 0;
        end
        out_ready = 1;
      end
      if (i == N - 1) start = start_noise;
      #1;
      res[i] = out_data; idx[i] = out_index;
      if (done === 1) n_done++;
      tick(); start = 0;
    end
    out_ready = 0;
    if (start_noise && busy !== 0) obs_bad++;
    #1;
    if (done === 1) n_done++;
  endtask

  logic [31:0] a   [16];
  logic [31:0] res [16];
  logic [3:0]  idx [16];
  int          n_done, obs_bad;
  bit          tmo;

  task automatic test_reset();
    rst = 1; start = 0; in_valid = 0; out_ready = 0; in_data = 0;
    tick(); #1;
    checks++; if (arr_rst !== 1) begin errors++; $display("FAIL reset_arr_rst: got %b want 1", arr_rst); end
    tick(); rst = 0; #1;
    checks++; if (busy !== 0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (in_ready !== 0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    checks++; if (out_valid !== 0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (out_index !== 0) begin errors++; $display("FAIL reset_out_index: got %0d want 0", out_index); end
    checks++; if (arr_lane0 !== 0 || arr_lane1 !== 0) begin errors++; $display("FAIL reset_lanes: got %0d/%0d want 0/0", arr_lane0, arr_lane1); end
    in_valid = 1; #1;
    checks++; if (arr_en_index !== 0) begin errors++; $display("FAIL reset_en_index: got %0d want 0", arr_en_index); end
    in_valid = 0;
  endtask

  task automatic test_impulse();
    for (int k = 0; k < 16; k++) a[k] = (k == 0) ? 32'd1 : 32'd0;
    run_xform(a, 0, -1, 0, res, idx, n_done, obs_bad, tmo);
    checks++; if (tmo) begin errors++; $display("FAIL impulse_timeout: got 1 want 0"); end
    for (int i = 0; i < 16; i++) begin
      checks++; if (res[i] !== 1) begin errors++; $display("FAIL impulse_X%0d: got %0d want 1", i, res[i]); end
      checks++; if (idx[i] !== 4'(i)) begin errors++; $display("FAIL impulse_index%0d: got %0d want %0d", i, idx[i], i); end
    end
    checks++; if (n_done !== 1) begin errors++; $display("FAIL impulse_done_pulses: got %0d want 1", n_done); end
    checks++; if (obs_bad !== 0) begin errors++; $display("FAIL impulse_load: got %0d bad cycles want 0", obs_bad); end
  endtask

  task automatic test_shifted_impulse();
    for (int k = 0; k < 16; k++) a[k] = (k == 1) ? 32'd1 : 32'd0;
    run_xform(a, 0, -1, 0, res, idx, n_done, obs_bad, tmo);
    checks++; if (res[0] !== 1) begin errors++; $display("FAIL shifted_X0: got %0d want 1", res[0]); end
    checks++; if (res[1] !== 7098) begin errors++; $display("FAIL shifted_X1: got %0d want 7098", res[1]); end
    checks++; if (res[2] !== 1925) begin errors++; $display("FAIL shifted_X2: got %0d want 1925", res[2]); end
    checks++; if (res[8] !== 7680) begin errors++; $display("FAIL shifted_X8: got %0d want 7680", res[8]); end
    checks++; if (res[15] !== 7154) begin errors++; $display("FAIL shifted_X15: got %0d want 7154", res[15]); end
    for (int i = 0; i < 16; i++) begin
      checks++; if (res[i] !== golden(i, a)) begin errors++; $display("FAIL shifted_X%0d: got %0d want %0d", i, res[i], golden(i, a)); end
    end
  endtask

  task automatic test_ramp_bubbles();
    for (int k = 0; k < 16; k++) a[k] = 32'(k + 1);
    run_xform(a, 3, -1, 0, res, idx, n_done, obs_bad, tmo);
    checks++; if (obs_bad !== 0) begin errors++; $display("FAIL ramp_bubble_en: got %0d bad cycles want 0", obs_bad); end
    checks++; if (res[0] !== 136) begin errors++; $display("FAIL ramp_X0: got %0d want 136", res[0]); end
    for (int i = 0; i < 16; i++) begin
      checks++; if (res[i] !== golden(i, a)) begin errors++; $display("FAIL ramp_X%0d: got %0d want %0d", i, res[i], golden(i, a)); end
    end
    checks++; if (n_done !== 1) begin errors++; $display("FAIL ramp_done_pulses: got %0d want 1", n_done); end
  endtask

  task automatic test_backpressure();
    for (int k = 0; k < 16; k++) a[k] = 32'(k * 37 + 5);
    run_xform(a, 0, 4, 0, res, idx, n_done, obs_bad, tmo);
    checks++; if (obs_bad !== 0) begin errors++; $display("FAIL bp_frozen: got %0d bad cycles want 0", obs_bad); end
    for (int i = 0; i < 16; i++) begin
      checks++; if (idx[i] !== 4'(i) || res[i] !== golden(i, a)) begin
        errors++; $display("FAIL bp_X%0d: got idx %0d val %0d want idx %0d val %0d", i, idx[i], res[i], i, golden(i, a));
      end
    end
    checks++; if (n_done !== 1) begin errors++; $display("FAIL bp_done_pulses: got %0d want 1", n_done); end
  endtask

  task automatic test_reset_mid_stream();
    start = 1; tick(); start = 0;
    for (int k = 0; k < 16; k++) begin in_valid = 1; in_data = 32'(k); tick(); end
    in_valid = 0;
    for (int c = 0; c < 7; c++) tick();
    #1;
    checks++; if (arr_lane0 !== 7 || busy !== 1) begin errors++; $display("FAIL mid_stream_lane0: got %0d busy %b want 7 busy 1", arr_lane0, busy); end
    rst = 1; #1;
    checks++; if (arr_rst !== 1) begin errors++; $display("FAIL mid_reset_arr_rst: got %b want 1", arr_rst); end
    tick(); rst = 0; #1;
    checks++; if (busy !== 0 || out_valid !== 0 || in_ready !== 0) begin
      errors++; $display("FAIL mid_reset_idle: got busy %b out_valid %b in_ready %b want 0 0 0", busy, out_valid, in_ready);
    end
    for (int k = 0; k < 16; k++) a[k] = 32'(1000 + k * 13);
    run_xform(a, 0, -1, 0, res, idx, n_done, obs_bad, tmo);
    for (int i = 0; i < 16; i++) begin
      checks++; if (res[i] !== golden(i, a)) begin errors++; $display("FAIL after_reset_X%0d: got %0d want %0d", i, res[i], golden(i, a)); end
    end
    checks++; if (n_done !== 1) begin errors++; $display("FAIL after_reset_done_pulses: got %0d want 1", n_done); end
  endtask

  task automatic test_start_ignored();
    for (int k = 0; k < 16; k++) a[k] = 32'(7680 - k);
    run_xform(a, 0, 3, 1, res, idx, n_done, obs_bad, tmo);
    checks++; if (obs_bad !== 0) begin errors++; $display("FAIL start_noise: got %0d bad cycles want 0", obs_bad); end
    for (int i = 0; i < 16; i++) begin
      checks++; if (res[i] !== golden(i, a) || idx[i] !== 4'(i)) begin
        errors++; $display("FAIL start_noise_X%0d: got idx %0d val %0d want idx %0d val %0d", i, idx[i], res[i], i, golden(i, a));
      end
    end
    checks++; if (n_done !== 1) begin errors++; $display("FAIL start_noise_done_pulses: got %0d want 1", n_done); end
    tick(); tick();
    checks++; if (busy !== 0) begin errors++; $display("FAIL start_with_done: got busy %b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_shifted_impulse();
    test_ramp_bubbles();
    test_backpressure();
    test_reset_mid_stream();
    test_start_ignored();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
